// File: rtl/cnu_layer_control_unit.sv
//==============================================================================
// Module   : cnu_layer_control_unit
// Brief    : Layer-scheduling FSM for the CNU of a layered IB-LDPC decoder.
//            Optional macro CNU_ITER_AUTOSTOP_EN ends the frame after the
//            final layer of the last iteration.
// Revision : 1.0
//==============================================================================
`default_nettype none

module cnu_layer_control_unit #(
    parameter int QUAN_SIZE          = 4,
    parameter int LAYER_NUM          = 3,
    parameter int MAX_ITER           = 5,
    parameter int RESET_CYCLE        = 100,
    parameter int CNU_FUNC_CYCLE     = 4,
    parameter int CNU_PIPELINE_LEVEL = 4,
    parameter int PERMUTATION_LEVEL  = 2,
    parameter int PAGE_ALIGN_LEVEL   = 1,
    parameter int MEM_RD_LEVEL       = 2,
    parameter int FSM_STATE_NUM      = 8,
    localparam int SW                = $clog2(FSM_STATE_NUM)
) (
    input  logic          read_clk,
    input  logic          rstn,
    input  logic          fsm_en,
    input  logic          layer_finish,
    input  logic          termination,
    output logic          cnu_rd,
    output logic          c2v_mem_we,
    output logic          v2c_src,
    output logic          de_frame_start,
    output logic [SW-1:0] state
);

    localparam int RCW = (RESET_CYCLE > 2) ? $clog2(RESET_CYCLE) : 1;
    localparam int DW  = 8;

    localparam logic [RCW-1:0]          RST_SAT     = RCW'(RESET_CYCLE - 1);
    localparam logic [DW-1:0]           PIPE_LAST   = DW'(CNU_PIPELINE_LEVEL - 2);
    localparam logic [DW-1:0]           PERM_LAST   = DW'(PERMUTATION_LEVEL - 1);
    localparam logic [DW-1:0]           ALIGN_LAST  = DW'(PAGE_ALIGN_LEVEL - 1);
    localparam logic [MEM_RD_LEVEL-1:0] FETCH_FIRST = MEM_RD_LEVEL'(1);

    if (QUAN_SIZE < 1 || CNU_FUNC_CYCLE < 1 || CNU_PIPELINE_LEVEL < 2 ||
        PERMUTATION_LEVEL < 1 || PAGE_ALIGN_LEVEL < 1 || MEM_RD_LEVEL < 1 ||
        LAYER_NUM < 1 || MAX_ITER < 1 || FSM_STATE_NUM < 8) begin : g_param_error
        $error("cnu_layer_control_unit: illegal parameter combination");
    end

    typedef enum logic [SW-1:0] {
        INIT_LOAD  = SW'(0),
        MEM_FETCH  = SW'(1),
        CNU_PIPE   = SW'(2),
        CNU_OUT    = SW'(3),
        BS_WB      = SW'(4),
        PAGE_ALIGN = SW'(5),
        MEM_WB     = SW'(6),
        IDLE       = SW'(7)
    } state_t;

    state_t                  cur_state;
    state_t                  next_state;
    logic [RCW-1:0]          rst_cnt;
    logic                    rst_done;
    logic [MEM_RD_LEVEL-1:0] fetch_sr;
    logic [DW-1:0]           dwell_cnt;
    logic                    pend;
    logic [LAYER_NUM-1:0]    layer_cnt;
    logic [MAX_ITER-1:0]     iter_cnt;
    logic                    autostop;
    logic                    clear_cnt;
    logic                    advance_layer;

    assign rst_done = (rst_cnt == RST_SAT);
    assign state    = cur_state;

`ifdef CNU_ITER_AUTOSTOP_EN
    assign autostop = (cur_state == MEM_WB) && layer_cnt[LAYER_NUM-1] && iter_cnt[MAX_ITER-1];
`else
    assign autostop = 1'b0;
`endif

    assign clear_cnt     = termination || autostop;
    assign advance_layer = (cur_state == IDLE) && (pend || layer_finish) && !termination;

    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            cur_state <= INIT_LOAD;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            INIT_LOAD:  if (rst_done && fsm_en)            next_state = MEM_FETCH;
            MEM_FETCH:  if (fetch_sr[MEM_RD_LEVEL-1])      next_state = CNU_PIPE;
            CNU_PIPE:   if (dwell_cnt == PIPE_LAST)        next_state = CNU_OUT;
            CNU_OUT:                                       next_state = BS_WB;
            BS_WB:      if (dwell_cnt == PERM_LAST)        next_state = PAGE_ALIGN;
            PAGE_ALIGN: if (dwell_cnt == ALIGN_LAST)       next_state = MEM_WB;
            MEM_WB:     next_state = autostop ? INIT_LOAD : IDLE;
            IDLE:       if (pend || layer_finish)          next_state = MEM_FETCH;
            default:                                       next_state = INIT_LOAD;
        endcase
        // Termination overrides every other transition, including a pending layer.
        if (termination) begin
            next_state = INIT_LOAD;
        end
    end

    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            rst_cnt        <= '0;
            fetch_sr       <= '0;
            dwell_cnt      <= '0;
            pend           <= 1'b0;
            layer_cnt      <= LAYER_NUM'(1);
            iter_cnt       <= MAX_ITER'(1);
            cnu_rd         <= 1'b0;
            c2v_mem_we     <= 1'b0;
            v2c_src        <= 1'b0;
            de_frame_start <= 1'b0;
        end else begin
            if (!rst_done) begin
                rst_cnt <= rst_cnt + 1'b1;
            end

            fetch_sr  <= (next_state == MEM_FETCH && cur_state != MEM_FETCH) ? FETCH_FIRST
                                                                              : (fetch_sr << 1);
            dwell_cnt <= (next_state != cur_state) ? '0 : dwell_cnt + 1'b1;

            if (clear_cnt) begin
                pend      <= 1'b0;
                layer_cnt <= LAYER_NUM'(1);
                iter_cnt  <= MAX_ITER'(1);
            end else if (advance_layer) begin
                pend      <= 1'b0;
                layer_cnt <= (layer_cnt << 1) | (layer_cnt >> (LAYER_NUM - 1));
                // Iteration advances on wrap of the last layer and saturates at the top bit.
                if (layer_cnt[LAYER_NUM-1] && !iter_cnt[MAX_ITER-1]) begin
                    iter_cnt <= iter_cnt << 1;
                end
            end else if (layer_finish) begin
                pend <= 1'b1;
            end

            cnu_rd         <= (next_state == MEM_FETCH);
            c2v_mem_we     <= (next_state == MEM_WB);
            de_frame_start <= (cur_state == INIT_LOAD) && (next_state == MEM_FETCH);
            v2c_src        <= iter_cnt[0];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cnu_layer_control_unit.sv
//==============================================================================
// Module   : tb_cnu_layer_control_unit
// Brief    : Directed and randomized bench for cnu_layer_control_unit against
//            a trace-table reference model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_cnu_layer_control_unit;

    localparam int LAYERS    = 3;
    localparam int ITERS     = 5;
    localparam int RST_SAT   = 99;
    localparam int LAYER_LEN = 10;

    logic       read_clk = 1'b0;
    logic       rstn = 1'b0;
    logic       fsm_en = 1'b0;
    logic       layer_finish = 1'b0;
    logic       termination = 1'b0;
    logic       cnu_rd;
    logic       c2v_mem_we;
    logic       v2c_src;
    logic       de_frame_start;
    logic [2:0] state;

    always #5 read_clk = ~read_clk;

    cnu_layer_control_unit dut (
        .read_clk       (read_clk),
        .rstn           (rstn),
        .fsm_en         (fsm_en),
        .layer_finish   (layer_finish),
        .termination    (termination),
        .cnu_rd         (cnu_rd),
        .c2v_mem_we     (c2v_mem_we),
        .v2c_src        (v2c_src),
        .de_frame_start (de_frame_start),
        .state          (state)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a layer is a fixed trace of states, then IDLE (7).
    int trace [LAYER_LEN] = '{1, 1, 2, 2, 2, 3, 4, 4, 5, 6};
    int m_state, m_pos, m_rstcnt, m_iter, m_layer;
    bit m_pend, m_rd, m_we, m_fs, m_src;

    function automatic void model_reset();
        m_state = 0; m_pos = 0; m_rstcnt = 0; m_iter = 0; m_layer = 0;
        m_pend = 1'b0; m_rd = 1'b0; m_we = 1'b0; m_fs = 1'b0; m_src = 1'b0;
    endfunction

    function automatic void model_step(input bit lf, input bit term, input bit en);
        int nxt;
        int prev_iter;
        prev_iter = m_iter;
        nxt = m_state;
        if (term) begin
            nxt = 0; m_iter = 0; m_layer = 0; m_pend = 1'b0;
        end else if (m_state == 0) begin
            m_pend = m_pend | lf;
            if (m_rstcnt == RST_SAT && en) begin
                nxt = 1; m_pos = 0;
            end
        end else if (m_state == 7) begin
            if (m_pend || lf) begin
                nxt = 1; m_pos = 0; m_pend = 1'b0;
                if (m_layer == LAYERS - 1) begin
                    m_layer = 0;
                    if (m_iter < ITERS - 1) m_iter = m_iter + 1;
                end else begin
                    m_layer = m_layer + 1;
                end
            end
        end else begin
            m_pend = m_pend | lf;
            if (m_pos == LAYER_LEN - 1) begin
                nxt = 7;
`ifdef CNU_ITER_AUTOSTOP_EN
                if (m_layer == LAYERS - 1 && m_iter == ITERS - 1) begin
                    nxt = 0; m_iter = 0; m_layer = 0; m_pend = 1'b0;
                end
`endif
            end else begin
                m_pos = m_pos + 1;
                nxt = trace[m_pos];
            end
        end
        m_fs  = (m_state == 0) && (nxt == 1);
        m_rd  = (nxt == 1);
        m_we  = (nxt == 6);
        m_src = (prev_iter == 0);
        m_state = nxt;
        if (m_rstcnt < RST_SAT) m_rstcnt = m_rstcnt + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("state", 32'(state), m_state);
        check("cnu_rd", 32'(cnu_rd), 32'(m_rd));
        check("c2v_mem_we", 32'(c2v_mem_we), 32'(m_we));
        check("de_frame_start", 32'(de_frame_start), 32'(m_fs));
        check("v2c_src", 32'(v2c_src), 32'(m_src));
        check("iter_cnt", 32'(dut.iter_cnt), 32'(1) << m_iter);
        check("layer_cnt", 32'(dut.layer_cnt), 32'(1) << m_layer);
    endtask

    task automatic step(input bit lf, input bit term, input bit en);
        layer_finish = lf;
        termination  = term;
        fsm_en       = en;
        @(posedge read_clk);
        model_step(lf, term, en);
        #1;
        check_all();
    endtask

    task automatic run_until(input int target, input int limit, input bit rand_lf);
        int n;
        n = 0;
        while (m_state != target && n < limit) begin
            step(rand_lf ? ($urandom_range(0, 3) == 0) : 1'b0, 1'b0, 1'b1);
            n++;
        end
        check("wait_state_reached", 32'(state), target);
    endtask

    initial begin
        model_reset();
        rstn = 1'b0;
        #50;
        check_all();
        check("reset_iter", 32'(dut.iter_cnt), 32'h01);
        #50;
        rstn = 1'b1;

        // Startup: enable goes high at cycle 10, start only after the reset counter saturates.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 89; i++) step(1'b0, 1'b0, 1'b1);
        check("hold_init", 32'(state), 0);
        step(1'b0, 1'b0, 1'b1);
        check("start_state", 32'(state), 1);
        check("start_pulse", 32'(de_frame_start), 1);

        // First layer runs through and parks in IDLE.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1);
        check("idle_hold", 32'(state), 7);

        // Periodic layer_finish pulses drive layer and iteration counting.
        for (int p = 0; p < 14; p++) begin
            for (int c = 0; c < 21; c++) step(c == 20, 1'b0, 1'b1);
            if (p == 2) begin
                check("iter_after_3", 32'(dut.iter_cnt), 32'h02);
                for (int c = 0; c < 2; c++) step(1'b0, 1'b0, 1'b1);
                check("v2c_src_second_iter", 32'(v2c_src), 0);
            end
            if (p == 11) check("iter_after_12", 32'(dut.iter_cnt), 32'h10);
        end
        check("iter_saturated", 32'(dut.iter_cnt), 32'h10);

        // Early layer_finish in CNU_PIPE is remembered until IDLE.
        run_until(2, 30, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        run_until(7, 30, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("early_lf_resume", 32'(state), 1);

        // Termination with simultaneous layer_finish during CNU_PIPE.
        run_until(2, 30, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("term_state", 32'(state), 0);
        check("term_iter", 32'(dut.iter_cnt), 32'h01);
        check("term_rd", 32'(cnu_rd), 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 11) == 0, $urandom_range(0, 299) == 0,
                 $urandom_range(0, 7) != 0);
        end

        // Asynchronous reset mid-layer.
        run_until(4, 400, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_all();
        check("async_rst_state", 32'(state), 0);
        @(negedge read_clk);
        rstn = 1'b1;
        for (int i = 0; i < 130; i++) step($urandom_range(0, 7) == 0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cnu_layer_control_unit.md
Name: cnu_layer_control_unit

Overview:
- Layer-scheduling FSM for the check-node unit (CNU) of the layered IB-LDPC decoder.
- Sequences each layer through memory fetch, CNU pipeline, barrel-shift write-back, page alignment and C2V memory write.
- Generates the read, write and source-select strobes for the CNU datapath.
- Tracks the layer and iteration counts until the decoder asserts termination.

Parameters:
- QUAN_SIZE, 4, message quantisation width; interface uniformity only, no logic depends on it.
- LAYER_NUM, 3, number of layers per iteration.
- MAX_ITER, 5, maximum decoding iterations; width of iter_cnt. Set equal to the codebase MAX_ITER macro.
- RESET_CYCLE, 100, minimum cycles after reset release before INIT_LOAD may exit.
- CNU_FUNC_CYCLE, 4, CNU function latency.
- CNU_PIPELINE_LEVEL, 4, CNU pipeline depth; CNU_PIPE lasts CNU_PIPELINE_LEVEL-1 cycles.
- PERMUTATION_LEVEL, 2, barrel-shifter latency; BS_WB dwell in cycles.
- PAGE_ALIGN_LEVEL, 1, PAGE_ALIGN dwell in cycles.
- MEM_RD_LEVEL, 2, memory read latency; MEM_FETCH dwell in cycles.
- FSM_STATE_NUM, 8, number of states; the state width is SW = clog2(FSM_STATE_NUM).
- State encodings: INIT_LOAD=0, MEM_FETCH=1, CNU_PIPE=2, CNU_OUT=3, BS_WB=4, PAGE_ALIGN=5, MEM_WB=6, IDLE=7.

Ports:
- read_clk  in  1  sole clock; all logic on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- fsm_en  in  1  level enable; leaves INIT_LOAD when high.
- layer_finish  in  1  pulse: the downstream (VNU side) layer is done.
- termination  in  1  decoder stop request.
- cnu_rd  out  1  C2V/V2C memory read enable.
- c2v_mem_we  out  1  C2V memory write enable.
- v2c_src  out  1  V2C source select: 1 = channel messages (first iteration), 0 = VNU output.
- de_frame_start  out  1  single-cycle frame-start pulse.
- state  out  SW  current FSM state (registered).

Behaviour:
- Reset: all flops clear asynchronously on rstn=0.
  - state=INIT_LOAD; all outputs 0.
  - iter_cnt (internal, MAX_ITER bits, one-hot, hierarchically probed by benches) = 1.
  - layer_cnt (one-hot, LAYER_NUM bits) = 1.
  - Reset counter = 0; layer_finish pending flag = 0.
  - Reset mid-operation aborts everything immediately.
- Reset counter:
  - Counts read_clk cycles after release and saturates at RESET_CYCLE-1.
  - INIT_LOAD exits only when it is saturated and fsm_en=1.
- INIT_LOAD -> MEM_FETCH on that condition.
  - de_frame_start=1 for exactly that one cycle (registered with the transition).
- MEM_FETCH: cnu_rd=1; dwell MEM_RD_LEVEL cycles, tracked by a shift register; then CNU_PIPE.
- CNU_PIPE: dwell CNU_PIPELINE_LEVEL-1 cycles; then CNU_OUT.
- CNU_OUT: 1 cycle; then BS_WB.
- BS_WB: dwell PERMUTATION_LEVEL cycles; then PAGE_ALIGN.
- PAGE_ALIGN: dwell PAGE_ALIGN_LEVEL cycles; then MEM_WB.
- MEM_WB: c2v_mem_we=1 for 1 cycle; then IDLE.
- Layer timing with defaults: MEM_FETCH entry to MEM_WB exit = 2+3+1+2+1+1 = 10 cycles.
- layer_finish handling:
  - Sampled in every state and latched in a pending flag.
  - In IDLE with pending (or layer_finish) set: clear the flag, rotate layer_cnt left, go to MEM_FETCH.
  - If layer_cnt was at bit LAYER_NUM-1: it wraps to bit 0 and iter_cnt shifts left one position.
  - iter_cnt saturates at bit MAX_ITER-1 (stays there).
  - IDLE holds indefinitely without layer_finish; cnu_rd and c2v_mem_we stay 0 there.
- v2c_src: 1 while iter_cnt[0]=1 (first iteration), else 0. Registered; updates the cycle after the iteration shift.
- termination: 1 in any state forces next state = INIT_LOAD.
  - Resets iter_cnt, layer_cnt and the pending flag; the reset counter is not re-armed.
  - Takes priority over simultaneous layer_finish.
  - A new frame starts when fsm_en=1 and termination=0.
- fsm_en=0 outside INIT_LOAD has no effect; the current frame runs to completion or termination.
- Output decode is registered from next-state, so strobes align with the state register.

Optional Feature:
- Macro: CNU_ITER_AUTOSTOP_EN.
- Defined: on the MEM_WB -> IDLE transition of layer LAYER_NUM-1 while iter_cnt[MAX_ITER-1]=1, the FSM goes straight to INIT_LOAD and clears its counters, without waiting for termination.
- Undefined: iter_cnt saturates and the FSM loops layers until termination.

Test Plan:
- Reset/enable: rstn low 100 ns, fsm_en=1 at cycle 10 -> state stays 0 until reset counter reaches 99. Then one de_frame_start pulse and state=1, with cnu_rd=1 for 2 cycles.
- Layer sequence: after start -> state trace is 1,1,2,2,2,3,4,4,5,6,7. c2v_mem_we is high only during state 6. v2c_src=1 throughout the first iteration.
- Layer/iteration counting: layer_finish pulses every 21 cycles (LAYER_NUM=3) -> after 3 pulses iter_cnt=00010 and v2c_src drops to 0. After 12 pulses iter_cnt=10000 and it stays there on later pulses.
- Early layer_finish: pulse during CNU_PIPE -> latched; FSM leaves IDLE the cycle after entering it, with no pulse lost.
- Termination: termination=1 when iter_cnt[4]=1 in CNU_PIPE -> next state=0, iter_cnt=00001, outputs 0. Simultaneous layer_finish is ignored.
- Async reset mid-layer: rstn=0 while state=4 -> state=0 and all outputs 0 without waiting for a clock edge.
